// File: rtl/rr_arbiter4.sv
// Purpose : four-channel round-robin arbiter driving a registered 2-bit grant index to the 2-to-4 decoder.
// Latency : grant registered one cycle after a nonzero req is sampled in IDLE; each release is followed by one dead GAP cycle.
// Backpr. : no backpressure; a grant is held until done (or forced off by the hold timeout when RR_TIMEOUT_EN is defined).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   per-channel request, bit i = channel i
//   done       grantee releases the grant (looked at only while granting)
//   gnt_idx    registered index of the granted channel (decoder input)
//   gnt_valid  registered, high while gnt_idx is a live grant
//   timeout    registered one-cycle pulse in the GAP after a forced release
//
// Build option: define RR_TIMEOUT_EN to add the MAX_HOLD grant timeout.
// Without it, no hold counter exists and timeout is tied low.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;
  logic [1:0] idx_nxt;
  logic       valid_nxt;
  logic [1:0] pick;

  // Elaboration-time guard on the legal hold range.
  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter4: MAX_HOLD must be in 2..255");
    end
  endgenerate

`ifdef RR_TIMEOUT_EN
  localparam int HOLD_W = ($clog2(MAX_HOLD) < 1) ? 1 : $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              tout_nxt;
`endif

  // Rotating priority search. Walking the offsets from 3 down to 0 lets the
  // smallest offset from ptr overwrite the others, so ptr itself wins first.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick = ptr + 2'(k);
      end
    end
  end

  // Next-state logic. gnt_valid is registered, so its next value is simply
  // "the next state is GRANT"; gnt_idx only reloads on the IDLE->GRANT step,
  // which keeps it frozen for the whole grant.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    valid_nxt = 1'b0;
`ifdef RR_TIMEOUT_EN
    hold_nxt  = hold_cnt;
    tout_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          idx_nxt   = pick;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
`ifdef RR_TIMEOUT_EN
          hold_nxt  = '0;
`endif
        end
      end
      GRANT: begin
        valid_nxt = 1'b1;
        if (done) begin
          // Only a release moves the pointer: start after the releasing channel.
          state_nxt = GAP;
          ptr_nxt   = gnt_idx + 2'd1;
          valid_nxt = 1'b0;
        end
`ifdef RR_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          // Forced release: same pointer advance as a normal release, plus a
          // timeout pulse that lives only in the GAP cycle.
          state_nxt = GAP;
          ptr_nxt   = gnt_idx + 2'd1;
          valid_nxt = 1'b0;
          tout_nxt  = 1'b1;
        end else begin
          hold_nxt  = hold_cnt + 1'b1;
        end
`endif
      end
      GAP: begin
        // Dead cycle so decoded enables of successive grantees never overlap.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
    end
  end

`ifdef RR_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      timeout  <= tout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  int checks   = 0;
  int failures = 0;

  // Expected index of each new grant, in order of issue.
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of gnt_valid pops one expected index; while a
  // grant stays valid its index must not move.
  logic       prev_v   = 1'b0;
  logic [1:0] prev_idx = 2'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (gnt_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", {30'd0, gnt_idx}, 32'hFFFF_FFFF);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("grant_idx", {30'd0, gnt_idx}, {30'd0, e});
        end
      end else if (gnt_valid && prev_v) begin
        check("idx_stable", {30'd0, gnt_idx}, {30'd0, prev_idx});
      end
      prev_v   = gnt_valid;
      prev_idx = gnt_idx;
    end
  end

  initial begin
    int         vcnt;
    logic [14:0] pat;
    logic [7:0] vpat;
    logic [7:0] tpat;

    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid",   {31'd0, gnt_valid}, 32'd0);
    check("rst_idx",     {30'd0, gnt_idx},   32'd0);
    check("rst_timeout", {31'd0, timeout},   32'd0);
    rst_n = 1'b1;

    // Idle with no requests.
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      vcnt += int'(gnt_valid);
    end
    check("idle_no_grant", vcnt, 0);

    // Single request on ch2; done sampled two edges later. ptr -> 3.
    exp_q.push_back(2'd2);
    req = 4'b0100;
    @(negedge clk);
    check("single_valid", {31'd0, gnt_valid}, 32'd1);
    req = 4'b0000;
    @(negedge clk);
    check("single_still_valid", {31'd0, gnt_valid}, 32'd1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("single_release", {31'd0, gnt_valid}, 32'd0);
    @(negedge clk);

    // Wrap and skip: ch3 from ptr 3, ptr wraps to 0, ch0 idle -> ch1.
    exp_q.push_back(2'd3);
    req = 4'b1000;
    @(negedge clk);
    check("wrap_valid", {31'd0, gnt_valid}, 32'd1);
    req  = 4'b0000;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("wrap_release", {31'd0, gnt_valid}, 32'd0);
    @(negedge clk);
    exp_q.push_back(2'd1);
    req = 4'b0110;
    @(negedge clk);
    check("skip_valid", {31'd0, gnt_valid}, 32'd1);
    req  = 4'b0000;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);

    // Ignored inputs: ptr 2, only ch0 requests, then drops its request.
    exp_q.push_back(2'd0);
    req = 4'b0001;
    @(negedge clk);
    req  = 4'b0000;
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      vcnt += int'(gnt_valid);
    end
    check("req_drop_holds", vcnt, 3);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    // done in IDLE must neither grant nor move ptr (still 1).
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("done_idle_a", {31'd0, gnt_valid}, 32'd0);
    @(negedge clk);
    check("done_idle_b", {31'd0, gnt_valid}, 32'd0);
    exp_q.push_back(2'd1);
    req = 4'b1111;
    @(negedge clk);
    check("after_idle_done_valid", {31'd0, gnt_valid}, 32'd1);
    req  = 4'b0000;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);

    // Async reset mid-grant: ptr 2 -> ch2 granted, then reset between edges.
    exp_q.push_back(2'd2);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    check("pre_reset_valid", {31'd0, gnt_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid",   {31'd0, gnt_valid}, 32'd0);
    check("async_rst_idx",     {30'd0, gnt_idx},   32'd0);
    check("async_rst_timeout", {31'd0, timeout},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotation from ptr 0 with all requests and done held high.
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    req  = 4'b1111;
    done = 1'b1;
    pat  = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      pat = {pat[13:0], gnt_valid};
    end
    req  = 4'b0000;
    done = 1'b0;
    check("rotation_valid_pattern", {17'd0, pat}, {17'd0, 15'b100100100100100});

    // Hold without done; ptr 1 and only ch0 requesting -> ch0.
    exp_q.push_back(2'd0);
    req  = 4'b0001;
    vpat = '0;
    tpat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vpat = {vpat[6:0], gnt_valid};
      tpat = {tpat[6:0], timeout};
      if (i == 0) req = 4'b0000;
    end
`ifdef RR_TIMEOUT_EN
    check("hold_valid_pattern",   {24'd0, vpat}, {24'd0, 8'b1111_0000});
    check("hold_timeout_pattern", {24'd0, tpat}, {24'd0, 8'b0000_1000});
`else
    check("hold_valid_pattern",   {24'd0, vpat}, {24'd0, 8'b1111_1111});
    check("hold_timeout_pattern", {24'd0, tpat}, 32'd0);
`endif
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);

    // done on the 4th grant cycle: normal release, no timeout pulse. ptr 1 -> ch0.
    exp_q.push_back(2'd0);
    req  = 4'b0001;
    vpat = '0;
    tpat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vpat = {vpat[6:0], gnt_valid};
      tpat = {tpat[6:0], timeout};
      if (i == 0) req = 4'b0000;
      if (i == 3) done = 1'b1;
      if (i == 4) done = 1'b0;
    end
    check("done_tc_valid_pattern",   {24'd0, vpat}, {24'd0, 8'b1111_0000});
    check("done_tc_timeout_pattern", {24'd0, tpat}, 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-channel round-robin arbiter that sits directly upstream of the 2-to-4 decoder stage. It accepts four request lines, picks one fairly, and presents a registered 2-bit grant index plus a valid flag. The downstream decoder turns the index into a one-hot enable. A guaranteed one-cycle dead gap between grants ensures decoded enables never overlap.

## Interface
- `MAX_HOLD`, default 8: maximum number of cycles a grant stays valid when timeout is compiled in. Legal range 2..255. The hold counter width is `$clog2(MAX_HOLD)`, minimum 1.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `req`  input  4: request per channel; bit i = channel i.
- `done`  input  1: current grantee releases the grant. Sampled only in GRANT.
- `gnt_idx`  output  2: registered index of the granted channel. Feeds the decoder `in`.
- `gnt_valid`  output  1: registered; high while `gnt_idx` is a live grant.
- `timeout`  output  1: registered one-cycle pulse marking a forced release.

## Operation
- States: IDLE, GRANT, GAP. Internal round-robin pointer `ptr[1:0]`.
- IDLE:
  - If `req != 0`, select the first set bit searching `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - Load `gnt_idx`, clear the hold counter, go to GRANT.
  - If `req == 0`, stay in IDLE; `gnt_idx` keeps its old value.
- GRANT:
  - `gnt_valid = 1`. `gnt_idx` is frozen; changes on `req` are ignored, including the grantee dropping its request.
  - If `done = 1`: release. Go to GAP and set `ptr <= gnt_idx + 1` (mod 4, so 3 wraps to 0).
  - Otherwise the hold counter increments.
- GAP:
  - `gnt_valid = 0` for exactly one cycle, then IDLE.
  - `req` and `done` are ignored.
- Only a release moves `ptr`. The pointer never advances in IDLE.
- Fairness: with all four requests held high, grants rotate 0,1,2,3,0,...
- `done` outside GRANT has no effect.

## Timing
- Reset (async, immediate): state IDLE, `ptr = 0`, hold counter 0, `gnt_idx = 2'd0`, `gnt_valid = 0`, `timeout = 0`.
  - Reset asserted mid-grant drops `gnt_valid` immediately, without waiting for a clock edge.
- Grant latency: if `req` is sampled nonzero at edge N in IDLE, `gnt_valid` and `gnt_idx` are valid after edge N (one cycle).
- Release: if `done` is sampled at edge M in GRANT, `gnt_valid` falls after edge M.
  - Earliest next grant: `gnt_valid` rises after edge M+2 (GAP at M+1, arbitration at M+2).
  - Minimum 3-cycle grant period per channel switch; minimum grant length 1 cycle.
- Hold counter is 0 in the first GRANT cycle and increments on each edge where `done = 0`.
- `gnt_idx` never changes while `gnt_valid = 1`.

## Configuration
- `RR_TIMEOUT_EN` defined:
  - In GRANT, if the hold counter equals `MAX_HOLD-1` and `done = 0` at an edge, force a release: go to GAP, advance `ptr` as for a normal release, and pulse `timeout = 1` during the GAP cycle only.
  - `gnt_valid` is therefore high for at most `MAX_HOLD` cycles.
  - If `done = 1` on the terminal-count edge, the release counts as normal and `timeout` stays 0.
- `RR_TIMEOUT_EN` undefined:
  - No hold counter is synthesized, and `MAX_HOLD` is unused.
  - A grant persists until `done`.
  - `timeout` is tied to 0.

## Test plan
- Reset then idle: assert `rst_n = 0` mid-GRANT → `gnt_valid = 0`, `gnt_idx = 0`, `timeout = 0` with no clock edge. With `req = 4'b0000` for 5 cycles after reset → `gnt_valid` stays 0.
- Single request: `req = 4'b0100` at edge 1 → `gnt_idx = 2`, `gnt_valid = 1` after edge 1. `done = 1` at edge 3 → `gnt_valid = 0` after edge 3.
- Rotation: `req = 4'b1111` held, `done` pulsed in every GRANT cycle → `gnt_idx` sequence 0,1,2,3,0, with `gnt_valid` pattern 1,0,0 repeating.
- Wrap and skip: grant ch3 from `req = 4'b1000`, release, then `req = 4'b0110` → next grant is `gnt_idx = 1`, because `ptr` wrapped from 3 to 0 and ch0 is not requesting.
- Timeout (`RR_TIMEOUT_EN`, `MAX_HOLD = 4`): `req = 4'b0001`, `done` held 0 → `gnt_valid` high for exactly 4 cycles, then `timeout = 1` for exactly 1 cycle. Repeat with `done = 1` on the 4th cycle → `timeout` stays 0.
- Ignored inputs: drop `req[gnt_idx]` during GRANT → `gnt_valid` stays 1. Pulse `done` in IDLE → no state change.
